line_access_arbiter: RTL and testbench

LINE_ACCESS_ARBITER -- requirements
Module: line_access_arbiter

---
 rtl/line_access_arbiter.sv | 139 +++++++++++++
 tb/tb_line_access_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/line_access_arbiter.sv
// line_access_arbiter
//   Arbitrates an instruction read port and a data read/write port onto a
//   single line array with a fixed access latency of LAT cycles (1..7).
//   Each transaction runs IDLE -> ACCESS (LAT cycles) -> DONE (1 cycle).
//   Simultaneous requests alternate by round-robin. After reset the
//   instruction port wins the first tie.
// Ports
//   clk, rst_n           clock, async active-low reset
//   i_req/i_line/i_ack   instruction port: read-only, ack is a 1-cycle pulse
//   d_req/d_we/d_line/d_wdata/d_ack
//                        data port: read or write, ack is a 1-cycle pulse
//   rdata                read data of the last completed read (both ports)
//   arr_en/arr_we/arr_line/arr_wdata/arr_rdata
//                        array side. arr_rdata is sampled in the last ACCESS cycle.
//   busy                 high whenever a transaction is in flight
module line_access_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [6:0]  i_line,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [6:0]  d_line,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] rdata,
  output logic        arr_en,
  output logic        arr_we,
  output logic [6:0]  arr_line,
  output logic [15:0] arr_wdata,
  input  logic [15:0] arr_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_q, last_d;     // port granted last: 0 = instr, 1 = data
  logic        gnt_q, gnt_d;       // port owning the current transaction
  logic        we_q, we_d;
  logic [6:0]  line_q, line_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        en_q, en_d;
  logic        arr_we_q, arr_we_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    line_d  = line_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // A tie goes to the port that did not win last time.
          gnt_d   = (i_req && d_req) ? ~last_q : d_req;
          last_d  = gnt_d;
          line_d  = gnt_d ? d_line : i_line;
          we_d    = gnt_d & d_we;
          // The instruction port has no write data, so the previous value is kept.
          if (gnt_d) wdata_d = d_wdata;
          cnt_d   = 3'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT_M1) begin
          if (!we_q) rdata_d = arr_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The outputs are decoded from the next state so they come straight from flops.
    en_d     = (state_d == ACCESS);
    arr_we_d = (state_d == ACCESS) & we_d;
    i_ack_d  = (state_d == DONE) & ~gnt_d;
    d_ack_d  = (state_d == DONE) &  gnt_d;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      line_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      en_q     <= 1'b0;
      arr_we_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      line_q   <= line_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      i_ack_q  <= i_ack_d;
      d_ack_q  <= d_ack_d;
      en_q     <= en_d;
      arr_we_q <= arr_we_d;
      busy_q   <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign rdata     = rdata_q;
  assign arr_en    = en_q;
  assign arr_we    = arr_we_q;
  assign arr_line  = line_q;
  assign arr_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_line_access_arbiter.sv
module tb_line_access_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [6:0]  i_line = '0, d_line = '0;
  logic [15:0] d_wdata = '0, arr_rdata = '0;
  logic        i_ack, d_ack, arr_en, arr_we, busy;
  logic [15:0] rdata, arr_wdata;
  logic [6:0]  arr_line;

  always #5 clk = ~clk;

  line_access_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_line(i_line), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_line(d_line), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .arr_en(arr_en), .arr_we(arr_we), .arr_line(arr_line),
    .arr_wdata(arr_wdata), .arr_rdata(arr_rdata), .busy(busy)
  );

  int n_cmp = 0, n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference. m_t is the position inside the current
  // transaction: 0 = idle, 1..LAT = array access, LAT+1 = ack cycle.
  int          m_t;
  bit          m_last, m_port, m_we;
  logic [6:0]  m_line;
  logic [15:0] m_wdata, m_rdata;

  function automatic bit pick(input bit ir, input bit dr, input bit last);
    return (ir && dr) ? !last : dr;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_last <= 1'b1; m_port <= 1'b0; m_we <= 1'b0;
      m_line <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (m_t == 0) begin
      if (i_req || d_req) begin
        m_port <= pick(i_req, d_req, m_last);
        m_last <= pick(i_req, d_req, m_last);
        m_line <= pick(i_req, d_req, m_last) ? d_line : i_line;
        m_we   <= pick(i_req, d_req, m_last) && d_we;
        if (pick(i_req, d_req, m_last)) m_wdata <= d_wdata;
        m_t    <= 1;
      end
    end else if (m_t <= LAT) begin
      if (m_t == LAT && !m_we) m_rdata <= arr_rdata;
      m_t <= m_t + 1;
    end else begin
      m_t <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("en",       32'(arr_en), 32'(m_t >= 1 && m_t <= LAT));
      chk("we",       32'(arr_we), 32'(m_t >= 1 && m_t <= LAT && m_we));
      chk("i_ack",    32'(i_ack),  32'(m_t == LAT + 1 && !m_port));
      chk("d_ack",    32'(d_ack),  32'(m_t == LAT + 1 && m_port));
      chk("busy",     32'(busy),   32'(m_t != 0));
      chk("rdata",    32'(rdata),  32'(m_rdata));
      chk("line",     32'(arr_line), 32'(m_line));
      chk("ack_excl", 32'(i_ack & d_ack), 32'd0);
      if (m_t >= 1 && m_t <= LAT && m_we) chk("wdata", 32'(arr_wdata), 32'(m_wdata));
    end
  end

  // Observes n cycles; cycle 1 is the first cycle after the current edge.
  int en_n, we_n, bad_line;
  int ackp[$], ackc[$];
  task automatic watch(input int n, input bit drop, input logic [6:0] eline);
    en_n = 0; we_n = 0; bad_line = 0;
    ackp.delete(); ackc.delete();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (arr_en) begin
        en_n++;
        if (arr_line !== eline) bad_line++;
      end
      if (arr_we) we_n++;
      if (i_ack) begin ackp.push_back(0); ackc.push_back(c); if (drop) i_req = 1'b0; end
      if (d_ack) begin ackp.push_back(1); ackc.push_back(c); if (drop) d_req = 1'b0; end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ack",   32'({i_ack, d_ack}), 0);
    chk("rst_en_we", 32'({arr_en, arr_we}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_line",  32'(arr_line), 0);
    chk("rst_wdata", 32'(arr_wdata), 0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Single instruction read of line 0.
    @(negedge clk);
    i_req = 1'b1; i_line = 7'd0; arr_rdata = 16'hBEEF;
    watch(5, 1'b1, 7'd0);
    chk("rd_en_cycles", 32'(en_n), 2);
    chk("rd_ack_n",     32'(ackp.size()), 1);
    if (ackp.size() > 0) begin
      chk("rd_ack_port", 32'(ackp[0]), 0);
      chk("rd_ack_cyc",  32'(ackc[0]), 3);
    end
    chk("rd_rdata", 32'(rdata), 32'h0000BEEF);

    // Single data write of line 127.
    d_req = 1'b1; d_we = 1'b1; d_line = 7'd127; d_wdata = 16'h1234; arr_rdata = 16'h0F0F;
    watch(5, 1'b1, 7'd127);
    chk("wr_we_cycles", 32'(we_n), 2);
    chk("wr_bad_line",  32'(bad_line), 0);
    chk("wr_ack_n",     32'(ackp.size()), 1);
    if (ackp.size() > 0) chk("wr_ack_port", 32'(ackp[0]), 1);
    chk("wr_rdata", 32'(rdata), 32'h0000BEEF);
    chk("wr_wdata", 32'(arr_wdata), 32'h00001234);
    d_we = 1'b0;

    // Simultaneous requests right after reset: I, D, I, D every LAT+2 cycles.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_req = 1'b1; d_req = 1'b1; i_line = 7'd3; d_line = 7'd4; arr_rdata = 16'h5A5A;
    watch(16, 1'b0, 7'd0);
    i_req = 1'b0; d_req = 1'b0;
    chk("rr_ack_n", 32'(ackp.size()), 4);
    for (int i = 0; i < ackp.size() && i < 4; i++) begin
      chk("rr_port", 32'(ackp[i]), 32'(i % 2));
      chk("rr_cyc",  32'(ackc[i]), 32'(3 + 4 * i));
    end
    repeat (4) @(negedge clk);

    // One-cycle request pulse still completes.
    i_req = 1'b1; i_line = 7'd33;
    @(negedge clk);
    i_req = 1'b0;
    watch(4, 1'b0, 7'd33);
    chk("drop_ack_n", 32'(ackp.size()), 1);
    if (ackp.size() > 0) begin
      chk("drop_port", 32'(ackp[0]), 0);
      chk("drop_cyc",  32'(ackc[0]), 2);
    end

    // Reset during the second ACCESS cycle aborts the read.
    @(negedge clk);
    d_req = 1'b1; d_line = 7'd77; arr_rdata = 16'hC0DE;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0; d_req = 1'b0;
    #1;
    chk("ra_en",    32'({arr_en, arr_we}), 0);
    chk("ra_busy",  32'(busy), 0);
    chk("ra_ack",   32'({i_ack, d_ack}), 0);
    chk("ra_rdata", 32'(rdata), 0);
    chk("ra_line",  32'(arr_line), 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(6, 1'b0, 7'd0);
    chk("ra_no_ack", 32'(ackp.size()), 0);
    chk("ra_no_en",  32'(en_n), 0);

    // A line change during ACCESS is ignored.
    d_req = 1'b1; d_line = 7'd5; d_we = 1'b0;
    @(negedge clk);
    chk("mc_line_a", 32'(arr_line), 5);
    d_line = 7'd9;
    watch(4, 1'b1, 7'd5);
    chk("mc_bad_line", 32'(bad_line), 0);
    chk("mc_ack_n",    32'(ackp.size()), 1);
    chk("mc_line_end", 32'(arr_line), 5);

    // Random traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      i_req     = 1'($urandom_range(0, 1));
      d_req     = 1'($urandom_range(0, 1));
      d_we      = 1'($urandom_range(0, 1));
      i_line    = 7'($urandom);
      d_line    = 7'($urandom);
      d_wdata   = 16'($urandom);
      arr_rdata = 16'($urandom);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
